// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants: instruction width, jump opcodes and
// the {pc, instr} entry handed from fetch to decode.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
    return (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
  endfunction

  // Absolute J/JAL target: upper nibble comes from the delay-slot PC.
  function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                              input logic [INSTR_W-1:0] instr);
    logic [31:0] pc_plus4;
    pc_plus4 = pc + 32'd4;
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small flop-based FIFO with synchronous clear and occupancy count; the head
// entry is readable combinationally so it can be consumed in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_rd [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign do_pop    = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign count     = count_reg;
  assign head_data = mem_rd[rd_ptr_reg];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg <= '0;
      end else if (do_push && !clr && (wr_ptr_reg == PTR_W'(gi))) begin
        data_reg <= push_data;
      end
    end

    assign mem_rd[gi] = data_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// PC generation, in-order IMEM fetch and a small fetch buffer feeding decode.
// Define JUMP_PREDECODE_EN to redirect fetch early on J/JAL words as they return.
module instruction_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic               started_reg;
  logic [31:0]        pc_reg;
  logic [CNT_W-1:0]   drop_cnt_reg;

  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [31:0]        tag_head;
  logic [CNT_W-1:0]   tag_count;
  logic               tag_empty;

  logic               req_fire;
  logic               pop_fire;
  logic               rsp_keep;
  logic               jump_hit;
  logic [31:0]        jump_pc;
  logic [SUM_W-1:0]   credit_used;
  logic [SUM_W-1:0]   inflight_after;

  // Requests in flight are the tagged ones plus those already marked for dropping.
  assign credit_used    = SUM_W'(drop_cnt_reg) + SUM_W'(tag_count) + SUM_W'(fifo_count)
                        - SUM_W'(pop_fire);
  assign inflight_after = SUM_W'(drop_cnt_reg) + SUM_W'(tag_count) - SUM_W'(imem_rsp_valid);

  assign pop_fire = if_valid && if_ready;
  assign rsp_keep = imem_rsp_valid && (drop_cnt_reg == '0) && !tag_empty && !redirect_valid;

`ifdef JUMP_PREDECODE_EN
  assign jump_hit = rsp_keep && is_jump(imem_rsp_data);
  assign jump_pc  = jump_target(tag_head, imem_rsp_data);
`else
  assign jump_hit = 1'b0;
  assign jump_pc  = '0;
`endif

  assign imem_req_valid = started_reg && !redirect_valid && !jump_hit
                       && (credit_used < SUM_W'(FIFO_DEPTH));
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push_entry = '{pc: tag_head, instr: imem_rsp_data};
  assign if_valid   = !fifo_empty;
  assign if_pc      = head_entry.pc;
  assign if_instr   = head_entry.instr;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_entry_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (redirect_valid),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop_fire),
    .head_data (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // The jump word itself is kept; only younger in-flight requests are discarded.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (redirect_valid || jump_hit),
    .push      (req_fire),
    .push_data (pc_reg),
    .pop       (rsp_keep),
    .head_data (tag_head),
    .count     (tag_count),
    .empty     (tag_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_reg  <= 1'b0;
      pc_reg       <= RESET_PC;
      drop_cnt_reg <= '0;
    end else begin
      started_reg <= 1'b1;
      if (redirect_valid) begin
        pc_reg       <= {redirect_pc[31:2], 2'b00};
        drop_cnt_reg <= CNT_W'(inflight_after);
      end else if (jump_hit) begin
        pc_reg       <= jump_pc;
        drop_cnt_reg <= CNT_W'(inflight_after);
      end else begin
        if (req_fire) pc_reg <= pc_reg + 32'd4;
        if (imem_rsp_valid && (drop_cnt_reg != '0)) drop_cnt_reg <= drop_cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: behavioural IMEM with variable
// latency, a scoreboard of expected {pc, instr} and a second instance for RESET_PC wrap.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;

  logic        req_valid2;
  logic        req_ready2 = 1'b1;
  logic [31:0] req_addr2;
  logic        rsp_valid2 = 1'b0;
  logic [31:0] rsp_data2 = '0;
  logic        redir_valid2 = 1'b0;
  logic [31:0] redir_pc2 = '0;
  logic        if_valid2;
  logic        if_ready2 = 1'b1;
  logic [31:0] if_instr2, if_pc2;

  always #5 clk = ~clk;

  instruction_fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid2), .imem_req_ready(req_ready2), .imem_req_addr(req_addr2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .redirect_valid(redir_valid2), .redirect_pc(redir_pc2),
    .if_valid(if_valid2), .if_ready(if_ready2), .if_instr(if_instr2), .if_pc(if_pc2)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] tgt; int lat; int inflight; logic [31:0] exp_pc; } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          imem_lat = 1;
  int          accept_cnt = 0;
  int          hs_cnt = 0;
  int          first_hs_cyc = -1;
  int          last_hs_cyc = -1;
  logic        jump_word_en = 1'b0;
  logic [31:0] last_rsp_addr = '0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  exp_t        exp_q[$];
  exp_t        exp2_q[$];
  exp_t        mon_e;
  exp_t        mon2_e;
  vec_t        tbl[4];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (jump_word_en && a == 32'h0000_0010) return 32'h0800_0040;
    return {6'h23, a[25:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Redirect in the current cycle and load the scoreboard with the stream expected after it.
  task automatic redirect_to(input logic [31:0] tgt, input logic [31:0] first, input int n_exp);
    exp_q.delete();
    for (int i = 0; i < n_exp; i++)
      exp_q.push_back('{pc: first + 32'(4 * i), instr: instr_of(first + 32'(4 * i))});
    redirect_pc    = tgt;
    redirect_valid = 1'b1;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    n = 0;
    if_ready = 1'b1;
    while (exp_q.size() > 0 && n < bound) begin
      step(1);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: %0d expected entries never delivered, required 0", name, exp_q.size());
    end
    if_ready = 1'b0;
  endtask

  // IMEM model for dut: in-order responses imem_lat cycles after accept.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      cyc = 0;
      accept_cnt = 0;
      q_addr.delete();
      q_due.delete();
      imem_rsp_valid <= 1'b0;
    end else begin
      cyc++;
      if (imem_req_valid && imem_req_ready) begin
        accept_cnt++;
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + imem_lat - 1);
      end
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        last_rsp_addr = q_addr.pop_front();
        void'(q_due.pop_front());
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= instr_of(last_rsp_addr);
      end else begin
        imem_rsp_valid <= 1'b0;
        imem_rsp_data  <= 32'hDEAD_BEEF;
      end
    end
  end

  // IMEM model for dut2: always ready, one-cycle latency.
  initial forever begin
    @(posedge clk);
    rsp_valid2 <= rst_n && req_valid2;
    rsp_data2  <= instr_of(req_addr2);
  end

  // Scoreboard monitors: compare each handshake against the head of the expected queue.
  initial forever begin
    @(negedge clk);
    if (rst_n && !redirect_valid && if_valid && if_ready) begin
      if (hs_cnt == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got pc %h, required no output", if_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("if_pc", if_pc, mon_e.pc);
        check("if_instr", if_instr, mon_e.instr);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && if_valid2 && exp2_q.size() > 0) begin
      mon2_e = exp2_q.pop_front();
      check("wrap_if_pc", if_pc2, mon2_e.pc);
      check("wrap_if_instr", if_instr2, mon2_e.instr);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{tgt: 32'h0000_0102, lat: 3, inflight: 2, exp_pc: 32'h0000_0100};
    tbl[1] = '{tgt: 32'h0000_1000, lat: 1, inflight: 0, exp_pc: 32'h0000_1000};
    tbl[2] = '{tgt: 32'hFFFF_FFF7, lat: 1, inflight: 0, exp_pc: 32'hFFFF_FFF4};
    tbl[3] = '{tgt: 32'h0000_0043, lat: 2, inflight: 1, exp_pc: 32'h0000_0040};

    imem_req_ready = 1'b1;
    if_ready       = 1'b0;
    step(2);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0000_0000);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_req_addr2", req_addr2, 32'hFFFF_FFF8);

    // Sequential stream from reset, one instruction per cycle.
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{pc: 32'(4 * i), instr: instr_of(32'(4 * i))});
    exp2_q.push_back('{pc: 32'hFFFF_FFF8, instr: instr_of(32'hFFFF_FFF8)});
    exp2_q.push_back('{pc: 32'hFFFF_FFFC, instr: instr_of(32'hFFFF_FFFC)});
    exp2_q.push_back('{pc: 32'h0000_0000, instr: instr_of(32'h0000_0000)});
    hs_cnt   = 0;
    if_ready = 1'b1;
    rst_n    = 1'b1;
    drain("sequential", 20);
    check("first_out_cycle", 32'(first_hs_cyc), 32'd3);
    check("fourth_out_cycle", 32'(last_hs_cyc), 32'd6);

    // Decode stalled from reset: credit limits fetch to FIFO_DEPTH words.
    rst_n = 1'b0;
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (i >= 4) check("stall_hold_pc", if_pc, 32'h0000_0000);
    end
    check("stall_requests", 32'(accept_cnt), 32'd2);
    check("stall_if_valid", 32'(if_valid), 32'd1);
    check("stall_if_instr", if_instr, instr_of(32'h0));
    for (int i = 0; i < 3; i++)
      exp_q.push_back('{pc: 32'(4 * i), instr: instr_of(32'(4 * i))});
    drain("after_stall", 20);

    // Table of redirects: flush, optionally wait for in-flight requests, redirect, check stream.
    for (int i = 0; i < 4; i++) begin
      imem_lat = tbl[i].lat;
      redirect_to(32'h0000_0200, 32'h0000_0200, 0);
      n = 0;
      while (q_addr.size() < tbl[i].inflight && n < 50) begin
        step(1);
        n++;
      end
      check($sformatf("vec%0d_inflight", i), 32'(q_addr.size() >= tbl[i].inflight), 32'd1);
      redirect_to(tbl[i].tgt, tbl[i].exp_pc, 4);
      check($sformatf("vec%0d_flushed", i), 32'(if_valid), 32'd0);
      drain($sformatf("vec%0d", i), 60);
    end

    // Redirect in the very cycle a fresh word returns: that word must never be delivered.
    imem_lat = 1;
    redirect_to(32'h0000_0300, 32'h0000_0300, 0);
    n = 0;
    while (!(imem_rsp_valid && last_rsp_addr == 32'h0000_0300) && n < 20) begin
      step(1);
      n++;
    end
    check("coincident_rsp_seen", 32'(imem_rsp_valid), 32'd1);
    redirect_to(32'h0000_0500, 32'h0000_0500, 3);
    check("coincident_flushed", 32'(if_valid), 32'd0);
    drain("coincident", 40);

`ifdef JUMP_PREDECODE_EN
    jump_word_en = 1'b1;
    redirect_to(32'h0000_0008, 32'h0000_0008, 0);
    exp_q.push_back('{pc: 32'h0000_0008, instr: instr_of(32'h0000_0008)});
    exp_q.push_back('{pc: 32'h0000_000C, instr: instr_of(32'h0000_000C)});
    exp_q.push_back('{pc: 32'h0000_0010, instr: 32'h0800_0040});
    exp_q.push_back('{pc: 32'h0000_0100, instr: instr_of(32'h0000_0100)});
    exp_q.push_back('{pc: 32'h0000_0104, instr: instr_of(32'h0000_0104)});
    drain("jump_predecode", 40);
    jump_word_en = 1'b0;
`endif

    check("wrap_stream_done", 32'(exp2_q.size()), 32'd0);
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
